// File: rtl/dmem_stall_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
// Stall is a hold: while it is high the master keeps Rd/Wr/Addr/DataIn stable; Done marks the one
// cycle in which the access result is final and the master may advance.
interface dmem_stall_responder_if;
  logic        Rd;
  logic        Wr;
  logic        Halt;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Stall;
  logic        Done;
  logic        Busy;
  logic        err;

  modport master (
    output Rd, Wr, Halt, Addr, DataIn,
    input  DataOut, Stall, Done, Busy, err
  );

  modport slave (
    input  Rd, Wr, Halt, Addr, DataIn,
    output DataOut, Stall, Done, Busy, err
  );
endinterface

// File: rtl/dmem_stall_responder.sv
// Word-addressed data memory with a fixed multi-cycle access latency, pipeline stall,
// completion pulse, illegal-request flag and a terminal halt state.
module dmem_stall_responder #(
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 3   // BUSY cycles per access, 1..15
) (
  input  logic                   clk,
  input  logic                   rst,
  dmem_stall_responder_if.slave  bus,
  output logic [1:0]             state_o
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              halt_seen_q, halt_seen_d;
  logic [15:0]       dout_q, dout_d;
  logic              err_q, err_d;
  logic [15:0]       mem_q [DEPTH];

  logic req_any;
  logic legal;
  logic commit;
  logic stall;

  // Legal: exactly one of Rd/Wr, even byte address, nothing set above the word-index field.
  always_comb begin
    req_any = bus.Rd | bus.Wr;
    legal   = (bus.Rd ^ bus.Wr) && !bus.Addr[0] &&
              ((bus.Addr >> (ADDR_W + 1)) == 16'd0);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    halt_seen_d = halt_seen_q;
    err_d       = 1'b0;
    commit      = 1'b0;
    stall       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.Halt) begin
          state_d = ST_HALTED;
        end else if (legal) begin
          stall       = 1'b1;
          op_wr_d     = bus.Wr;
          idx_d       = bus.Addr[ADDR_W:1];
          wdata_d     = bus.DataIn;
          cnt_d       = CNT_LOAD;
          halt_seen_d = 1'b0;
          state_d     = ST_BUSY;
        end else if (req_any) begin
          err_d = 1'b1;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (bus.Halt) halt_seen_d = 1'b1;
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // The request is still on the bus here; it is intentionally not re-accepted.
        state_d     = (halt_seen_q || bus.Halt) ? ST_HALTED : ST_IDLE;
        halt_seen_d = 1'b0;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    if (commit && !op_wr_q) dout_d = mem_q[idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      op_wr_q     <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 16'd0;
      halt_seen_q <= 1'b0;
      dout_q      <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      halt_seen_q <= halt_seen_d;
      dout_q      <= dout_d;
      err_q       <= err_d;
    end
  end

  // Reset clears the whole array, so a write caught mid-access never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'd0;
    end else if (commit && op_wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.Stall   = stall;
  assign bus.Done    = (state_q == ST_DONE);
  assign bus.Busy    = (state_q == ST_BUSY);
  assign bus.err     = err_q;
  assign bus.DataOut = dout_q;
  assign state_o     = state_q;

endmodule
